// File: rtl/dm_cache.sv
// Direct-mapped, write-back, write-allocate cache with 32-byte lines held in flip-flops.
// A single CHECK/WRITEBACK/ALLOCATE controller services one CPU request at a time.
module dm_cache #(
    parameter int S_INDEX = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [3:0]   mem_byte_enable,
    input  logic [31:0]  mem_address,
    input  logic [31:0]  mem_wdata,
    output logic [31:0]  mem_rdata,
    output logic         mem_resp,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic [255:0] pmem_rdata,
    input  logic         pmem_resp
);

    localparam int SETS  = 1 << S_INDEX;
    localparam int TAG_W = 27 - S_INDEX;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t             state_r;
    logic               valid_r [SETS];
    logic               dirty_r [SETS];
    logic [TAG_W-1:0]   tag_r   [SETS];
    logic [255:0]       line_r  [SETS];

    logic [S_INDEX-1:0] index_s;
    logic [TAG_W-1:0]   tag_s;
    logic [2:0]         word_s;
    logic               req_s;
    logic               hit_s;
    logic [255:0]       cur_line_s;
    logic [31:0]        cur_word_s;
    logic [31:0]        merged_word_s;
    logic               unused_s;

    // Byte-masked merge of CPU write data into an existing word.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  be);
        logic [31:0] m;
        m = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                m[i*8 +: 8] = new_word[i*8 +: 8];
            end else begin
                m[i*8 +: 8] = old_word[i*8 +: 8];
            end
        end
        return m;
    endfunction

    assign index_s       = mem_address[4+S_INDEX:5];
    assign tag_s         = mem_address[31:5+S_INDEX];
    assign word_s        = mem_address[4:2];
    assign req_s         = mem_read | mem_write;
    assign cur_line_s    = line_r[index_s];
    assign cur_word_s    = cur_line_s[{word_s, 5'b00000} +: 32];
    assign hit_s         = valid_r[index_s] && (tag_r[index_s] == tag_s);
    assign merged_word_s = merge_bytes(cur_word_s, mem_wdata, mem_byte_enable);
    assign unused_s      = ^mem_address[1:0];

    // Output decode: CPU response is combinational on a hit, memory side follows the state.
    always_comb begin
        mem_resp     = 1'b0;
        mem_rdata    = 32'd0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = 32'd0;
        pmem_wdata   = 256'd0;
        case (state_r)
            CHECK: begin
                if (req_s && hit_s) begin
                    mem_resp  = 1'b1;
                    mem_rdata = cur_word_s;
                end else begin
                    mem_resp  = 1'b0;
                end
            end
            WRITEBACK: begin
                pmem_write   = 1'b1;
                pmem_address = {tag_r[index_s], index_s, 5'b00000};
                pmem_wdata   = cur_line_s;
            end
            ALLOCATE: begin
                pmem_read    = 1'b1;
                pmem_address = {tag_s, index_s, 5'b00000};
            end
            default: begin
                mem_resp = 1'b0;
            end
        endcase
    end

    // Controller state plus per-set valid/dirty bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= CHECK;
            for (int i = 0; i < SETS; i++) begin
                valid_r[i] <= 1'b0;
                dirty_r[i] <= 1'b0;
            end
        end else begin
            case (state_r)
                CHECK: begin
                    if (req_s && !hit_s) begin
                        state_r <= (valid_r[index_s] && dirty_r[index_s]) ? WRITEBACK : ALLOCATE;
                    end else if (req_s && mem_write) begin
                        dirty_r[index_s] <= 1'b1;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) begin
                        state_r <= ALLOCATE;
                    end
                end
                ALLOCATE: begin
                    if (pmem_resp) begin
                        valid_r[index_s] <= 1'b1;
                        dirty_r[index_s] <= 1'b0;
                        state_r          <= CHECK;
                    end
                end
                default: begin
                    state_r <= CHECK;
                end
            endcase
        end
    end

    // Line and tag storage; not cleared by reset, but never written while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst && (state_r == CHECK) && req_s && hit_s && mem_write) begin
            line_r[index_s][{word_s, 5'b00000} +: 32] <= merged_word_s;
        end else if (rst && (state_r == ALLOCATE) && pmem_resp) begin
            line_r[index_s] <= pmem_rdata;
            tag_r[index_s]  <= tag_s;
        end
    end

endmodule

// File: tb/tb_dm_cache.sv
// Directed self-checking bench for dm_cache: cold miss, hits, byte-masked writes,
// dirty eviction, reset during a fill and simultaneous read/write.
module tb_dm_cache;

    logic         clk = 1'b0;
    logic         rst;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   mem_byte_enable;
    logic [31:0]  mem_address;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata;
    logic         pmem_resp;

    int tests = 0;
    int fails = 0;

    logic [255:0] line_a;
    logic [255:0] line_a_mod;
    logic [255:0] line_b;
    logic [255:0] line_a_rw;

    dm_cache #(.S_INDEX(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_byte_enable(mem_byte_enable),
        .mem_address    (mem_address),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .mem_resp       (mem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            line_a[i*32 +: 32] = 32'hC0DE_0000 | i;
            line_b[i*32 +: 32] = 32'h5EED_0000 | i;
        end
        line_a_mod = line_a;
        line_a_mod[63:32] = 32'hC0DE_CCDD;
        line_a_rw = line_a;
        line_a_rw[63:32] = 32'h1234_0001;

        rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_byte_enable = 4'b0000;
        mem_address = 32'd0; mem_wdata = 32'd0; pmem_rdata = 256'd0; pmem_resp = 1'b0;
        tick(); tick();
        rst = 1'b1; #1;
        check("reset_mem_resp", mem_resp, 1'b0);
        check("reset_pmem_read", pmem_read, 1'b0);
        check("reset_pmem_write", pmem_write, 1'b0);

        // Cold read of 0x104, fill answers in the third ALLOCATE cycle
        mem_read = 1'b1; mem_address = 32'h0000_0104; #1;
        check("cold_miss_resp", mem_resp, 1'b0);
        check("cold_check_pmem_read", pmem_read, 1'b0);
        tick();
        check("cold_pmem_read", pmem_read, 1'b1);
        check("cold_pmem_addr", pmem_address, 32'h0000_0100);
        check("cold_pmem_write", pmem_write, 1'b0);
        check("cold_alloc_resp", mem_resp, 1'b0);
        tick(); tick();
        pmem_rdata = line_a; pmem_resp = 1'b1; #1;
        check("cold_fill_resp", mem_resp, 1'b0);
        tick();
        pmem_resp = 1'b0; pmem_rdata = 256'd0; #1;
        check("cold_done_resp", mem_resp, 1'b1);
        check("cold_rdata", mem_rdata, 32'hC0DE_0001);
        check("cold_done_pmem_read", pmem_read, 1'b0);

        // Idle, then repeat read hits immediately
        tick();
        mem_read = 1'b0; #1;
        check("idle_resp", mem_resp, 1'b0);
        tick();
        mem_read = 1'b1; #1;
        check("hit_resp", mem_resp, 1'b1);
        check("hit_rdata", mem_rdata, 32'hC0DE_0001);
        check("hit_pmem_read", pmem_read, 1'b0);
        check("hit_pmem_write", pmem_write, 1'b0);

        // Byte-masked write hit on the low half-word
        tick();
        mem_read = 1'b0; mem_write = 1'b1; mem_byte_enable = 4'b0011; mem_wdata = 32'hAABB_CCDD; #1;
        check("wr_hit_resp", mem_resp, 1'b1);
        tick();
        mem_write = 1'b0; mem_read = 1'b1; #1;
        check("wr_readback", mem_rdata, 32'hC0DE_CCDD);
        check("wr_readback_resp", mem_resp, 1'b1);

        // Same index, new tag: dirty line goes out before the fill
        tick();
        mem_address = 32'h0000_1104; #1;
        check("evict_miss_resp", mem_resp, 1'b0);
        tick();
        check("wb_pmem_write", pmem_write, 1'b1);
        check("wb_pmem_read", pmem_read, 1'b0);
        check("wb_addr", pmem_address, 32'h0000_0100);
        check("wb_data", pmem_wdata, line_a_mod);
        check("wb_resp", mem_resp, 1'b0);
        pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; #1;
        check("evict_alloc_read", pmem_read, 1'b1);
        check("evict_alloc_write", pmem_write, 1'b0);
        check("evict_alloc_addr", pmem_address, 32'h0000_1100);
        pmem_rdata = line_b; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; #1;
        check("evict_done_resp", mem_resp, 1'b1);
        check("evict_rdata", mem_rdata, 32'h5EED_0001);

        // Back to 0x104: freshly filled line is clean so no writeback; reset mid-fill
        tick();
        mem_address = 32'h0000_0104; #1;
        check("clean_miss_resp", mem_resp, 1'b0);
        tick();
        check("clean_alloc_read", pmem_read, 1'b1);
        check("clean_alloc_write", pmem_write, 1'b0);
        rst = 1'b0;
        tick();
        check("rst_alloc_pmem_read", pmem_read, 1'b0);
        check("rst_alloc_resp", mem_resp, 1'b0);
        rst = 1'b1; #1;
        check("post_rst_miss_resp", mem_resp, 1'b0);
        tick();
        check("post_rst_alloc_read", pmem_read, 1'b1);
        check("post_rst_alloc_addr", pmem_address, 32'h0000_0100);
        pmem_rdata = line_a; pmem_resp = 1'b1;
        tick();
        pmem_resp = 1'b0; #1;
        check("post_rst_rdata", mem_rdata, 32'hC0DE_0001);

        // Read and write together act as a write
        tick();
        mem_write = 1'b1; mem_byte_enable = 4'b1100; mem_wdata = 32'h1234_5678; #1;
        check("rw_resp", mem_resp, 1'b1);
        tick();
        mem_write = 1'b0; #1;
        check("rw_readback", mem_rdata, 32'h1234_0001);
        tick();
        mem_address = 32'h0000_1104;
        tick();
        check("rw_dirty_wb", pmem_write, 1'b1);
        check("rw_wb_data", pmem_wdata, line_a_rw);
        pmem_resp = 1'b1;
        tick();
        pmem_rdata = line_b;
        tick();
        pmem_resp = 1'b0; mem_read = 1'b0; #1;
        check("final_idle_pmem_read", pmem_read, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dm_cache.md
DM_CACHE -- requirements
Module: dm_cache

Interface
REQ-001 The block SHALL have one parameter: S_INDEX, default 3, number of set-index bits (2**S_INDEX sets).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_read  in  1  CPU read request, held until mem_resp.
- mem_write  in  1  CPU write request, held until mem_resp.
- mem_byte_enable  in  4  CPU write byte mask.
- mem_address  in  32  CPU byte address.
- mem_wdata  in  32  CPU write data.
- mem_rdata  out  32  CPU read data.
- mem_resp  out  1  CPU request complete.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- pmem_address  out  32  line address; bits [4:0] always 0.
- pmem_wdata  out  256  writeback line.
- pmem_rdata  in  256  fill line.
- pmem_resp  in  1  memory transaction complete.

Function
REQ-003 The block SHALL be a direct-mapped, write-back, write-allocate cache with 32-byte lines: offset = addr[4:0], index = addr[4+S_INDEX:5], tag = addr[31:5+S_INDEX].
REQ-004 Per set, the block SHALL store valid, dirty, tag and a 256-bit line in flip-flops; the word select is addr[4:2], and addr[1:0] is ignored.
REQ-005 The block SHALL implement three states: CHECK, WRITEBACK and ALLOCATE.
REQ-006 CHECK, hit (valid and tag match): mem_resp SHALL be 1 in the same cycle (combinational); the state stays CHECK.
REQ-007 On a read hit, mem_rdata SHALL be the selected word in that same cycle.
REQ-008 On a write hit, at the next clock edge each byte i of the selected word with mem_byte_enable[i]=1 SHALL take mem_wdata byte i, and dirty SHALL be set to 1.
REQ-009 CHECK, miss with valid=1 and dirty=1 SHALL transition to WRITEBACK.
REQ-010 CHECK, miss otherwise SHALL transition to ALLOCATE.
REQ-011 In CHECK with no request, or on a miss, mem_resp SHALL be 0.
REQ-012 In WRITEBACK, the block SHALL drive pmem_write=1, pmem_address={stored tag, index, 5'b0} and pmem_wdata=stored line, held until pmem_resp=1, then go to ALLOCATE.
REQ-013 In ALLOCATE, the block SHALL drive pmem_read=1 and pmem_address={req tag, index, 5'b0} until pmem_resp=1.
REQ-014 On pmem_resp=1 in ALLOCATE, at that edge the block SHALL load pmem_rdata into the line, set valid=1, dirty=0 and tag=req tag, and go to CHECK; the request then hits per REQ-006 to REQ-008.
REQ-015 pmem_read and pmem_write SHALL never both be 1.
REQ-016 pmem_* outputs SHALL be 0 in CHECK.
REQ-017 mem_resp SHALL be 0 in WRITEBACK and ALLOCATE.
REQ-018 If mem_read and mem_write are both 1, the request SHALL be treated as a write.
REQ-019 pmem_resp in CHECK SHALL be ignored.
REQ-020 Miss latency SHALL be: 1 + writeback wait (if dirty) + fill wait + 1 cycles to mem_resp.
REQ-021 The CPU request SHALL be assumed stable from issue until mem_resp; the block SHALL NOT latch it.

Reset
REQ-022 While rst=0 at a clock edge, the block SHALL clear all valid and dirty bits, set the state to CHECK, and drive mem_resp, pmem_read and pmem_write to 0 from the next cycle.
REQ-023 Reset asserted mid-WRITEBACK or mid-ALLOCATE SHALL abandon the transaction with no line update; line data and tag contents need not be cleared.

Verification
REQ-024 Cold read: reset, then mem_read addr 0x0000_0104 with fill returning line L after 3 cycles -> pmem_read=1, pmem_address 0x0000_0100; mem_resp one cycle after pmem_resp; mem_rdata=L[63:32].
REQ-025 Read hit: repeat the same read -> mem_resp=1 in the first cycle, no pmem activity.
REQ-026 Write hit: mem_write 0x0000_0104, mem_byte_enable 4'b0011, mem_wdata 0xAABB_CCDD -> word becomes {old[31:16],16'hCCDD}; a following read returns it; dirty=1.
REQ-027 Dirty eviction: read 0x0000_1104 (same index, new tag) -> pmem_write first at 0x0000_0100 with the modified line, then pmem_read at 0x0000_1100, then mem_resp.
REQ-028 Reset during ALLOCATE (rst=0 before pmem_resp) -> pmem_read=0 next cycle; a later read of the same address misses.
REQ-029 Simultaneous mem_read and mem_write hit -> write performed, dirty=1, single mem_resp.
